// File: rtl/exception_cp0.sv
// CP0 register file and exception arbiter; define CP0_TIMER_EN to build the Count/Compare timer.
// excepttype/rdata_o are combinational, all state updates at posedge clk; no backpressure, mtc0 dropped on exception.
module exception_cp0 #(
   parameter logic [31:0] PRID_VAL = 32'h00004220
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  int_i,
   input  logic        instr_validM,
   input  logic [31:0] pcM,
   input  logic        is_in_delayslotM,
   input  logic [31:0] bad_addrM,
   input  logic        adel_ifM,
   input  logic        riM,
   input  logic        ovM,
   input  logic        syscallM,
   input  logic        breakM,
   input  logic        eretM,
   input  logic        adel_dataM,
   input  logic        adesM,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] rdata_o,
   output logic [31:0] excepttype,
   output logic [31:0] epc,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] badvaddr_o,
   output logic        timer_int_o
);

   logic [7:0]  status_im;
   logic        status_exl;
   logic        status_ie;
   logic        cause_bd;
   logic [7:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc_r;
   logic [31:0] badvaddr_r;
   logic [31:0] count_rd;
   logic [31:0] compare_rd;
   logic        ip15;

   logic        int_pend;
   logic [4:0]  exc_code;
   logic        is_eret;
   logic        bad_from_pc;
   logic        bad_from_data;
   logic        exc_take;
   logic        wen;

   assign status_o   = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
   assign cause_o    = {cause_bd, 15'b0, cause_ip, 1'b0, cause_exc, 2'b0};
   assign epc        = epc_r;
   assign badvaddr_o = badvaddr_r;

   assign int_pend = (|(cause_ip & status_im)) & status_ie & ~status_exl & instr_validM;

   always_comb begin
      excepttype    = 32'h0;
      exc_code      = 5'd0;
      is_eret       = 1'b0;
      bad_from_pc   = 1'b0;
      bad_from_data = 1'b0;
      if (int_pend) begin
         excepttype = 32'h1;
         exc_code   = 5'd0;
      end else if (adel_ifM) begin
         excepttype  = 32'h4;
         exc_code    = 5'd4;
         bad_from_pc = 1'b1;
      end else if (riM) begin
         excepttype = 32'ha;
         exc_code   = 5'd10;
      end else if (ovM) begin
         excepttype = 32'hc;
         exc_code   = 5'd12;
      end else if (syscallM) begin
         excepttype = 32'h8;
         exc_code   = 5'd8;
      end else if (breakM) begin
         excepttype = 32'h9;
         exc_code   = 5'd9;
      end else if (eretM) begin
         excepttype = 32'he;
         is_eret    = 1'b1;
      end else if (adel_dataM) begin
         excepttype    = 32'h4;
         exc_code      = 5'd4;
         bad_from_data = 1'b1;
      end else if (adesM) begin
         excepttype    = 32'h5;
         exc_code      = 5'd5;
         bad_from_data = 1'b1;
      end
   end

   assign exc_take = (excepttype != 32'h0) && !is_eret;
   // The faulting instruction is flushed, so its mtc0 must not land.
   assign wen      = we_i && (excepttype == 32'h0);

`ifdef CP0_TIMER_EN
   logic [31:0] count_r;
   logic [31:0] compare_r;
   logic        tick;
   logic        timer_int;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r   <= 32'h0;
         compare_r <= 32'h0;
         tick      <= 1'b0;
         timer_int <= 1'b0;
      end else begin
         tick <= ~tick;
         if (wen && waddr_i == 5'd9)
            count_r <= wdata_i;
         else if (tick)
            count_r <= count_r + 32'd1;
         if (wen && waddr_i == 5'd11)
            compare_r <= wdata_i;
         if (wen && waddr_i == 5'd11)
            timer_int <= 1'b0;
         else if (count_r == compare_r)
            timer_int <= 1'b1;
      end
   end

   assign count_rd    = count_r;
   assign compare_rd  = compare_r;
   assign ip15        = int_i[5] | timer_int;
   assign timer_int_o = timer_int;
`else
   assign count_rd    = 32'h0;
   assign compare_rd  = 32'h0;
   assign ip15        = int_i[5];
   assign timer_int_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_im  <= 8'h0;
         status_exl <= 1'b0;
         status_ie  <= 1'b0;
         cause_bd   <= 1'b0;
         cause_ip   <= 8'h0;
         cause_exc  <= 5'd0;
         epc_r      <= 32'h0;
         badvaddr_r <= 32'h0;
      end else begin
         cause_ip[7:2] <= {ip15, int_i[4:0]};
         if (wen && waddr_i == 5'd12) begin
            status_im  <= wdata_i[15:8];
            status_exl <= wdata_i[1];
            status_ie  <= wdata_i[0];
         end
         if (wen && waddr_i == 5'd13)
            cause_ip[1:0] <= wdata_i[9:8];
         if (wen && waddr_i == 5'd14)
            epc_r <= wdata_i;
         if (exc_take) begin
            status_exl <= 1'b1;
            cause_exc  <= exc_code;
            // A nested exception keeps the original return point.
            if (!status_exl) begin
               cause_bd <= is_in_delayslotM;
               epc_r    <= is_in_delayslotM ? pcM - 32'd4 : pcM;
            end
            if (bad_from_pc)
               badvaddr_r <= pcM;
            else if (bad_from_data)
               badvaddr_r <= bad_addrM;
         end else if (is_eret) begin
            status_exl <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata_o = 32'h0;
      case (raddr_i)
         5'd8:    rdata_o = badvaddr_r;
         5'd9:    rdata_o = count_rd;
         5'd11:   rdata_o = compare_rd;
         5'd12:   rdata_o = status_o;
         5'd13:   rdata_o = cause_o;
         5'd14:   rdata_o = epc_r;
         5'd15:   rdata_o = PRID_VAL;
         default: rdata_o = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_exception_cp0.sv
// Directed self-checking bench for exception_cp0 (timer checks follow CP0_TIMER_EN).
module tb_exception_cp0;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  int_i;
   logic        instr_validM;
   logic [31:0] pcM;
   logic        is_in_delayslotM;
   logic [31:0] bad_addrM;
   logic        adel_ifM, riM, ovM, syscallM, breakM, eretM, adel_dataM, adesM;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic [4:0]  raddr_i;
   logic [31:0] rdata_o;
   logic [31:0] excepttype;
   logic [31:0] epc;
   logic [31:0] status_o, cause_o, badvaddr_o;
   logic        timer_int_o;

   int passed = 0;
   int total  = 0;

   exception_cp0 dut (
      .clk(clk), .rst(rst), .int_i(int_i), .instr_validM(instr_validM), .pcM(pcM),
      .is_in_delayslotM(is_in_delayslotM), .bad_addrM(bad_addrM),
      .adel_ifM(adel_ifM), .riM(riM), .ovM(ovM), .syscallM(syscallM), .breakM(breakM),
      .eretM(eretM), .adel_dataM(adel_dataM), .adesM(adesM),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .raddr_i(raddr_i),
      .rdata_o(rdata_o), .excepttype(excepttype), .epc(epc), .status_o(status_o),
      .cause_o(cause_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_flags();
      adel_ifM = 0; riM = 0; ovM = 0; syscallM = 0; breakM = 0;
      eretM = 0; adel_dataM = 0; adesM = 0;
      is_in_delayslotM = 0;
   endtask

   task automatic rd(input logic [4:0] a);
      raddr_i = a;
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we_i = 1; waddr_i = a; wdata_i = d;
      step();
      we_i = 0;
   endtask

   task automatic do_eret();
      instr_validM = 1; eretM = 1;
      #1 chk("eret_type", excepttype, 32'he);
      step();
      clear_flags();
   endtask

   initial begin
      int n;
      rst = 1; int_i = 0; instr_validM = 0; pcM = 0; bad_addrM = 0;
      we_i = 0; waddr_i = 0; wdata_i = 0; raddr_i = 0;
      clear_flags();
      #12 rst = 0;
      #1;
      rd(12); chk("rst_status", rdata_o, 32'h00400000);
      rd(13); chk("rst_cause", rdata_o, 32'h0);
      rd(14); chk("rst_epc", rdata_o, 32'h0);
      rd(15); chk("rst_prid", rdata_o, 32'h00004220);
      chk("rst_type", excepttype, 32'h0);

      mtc0(5'd11, 32'hffffffff);

      // syscall with a same-cycle mtc0 EPC that must be dropped
      instr_validM = 1; syscallM = 1; pcM = 32'hbfc00100;
      we_i = 1; waddr_i = 5'd14; wdata_i = 32'h12345678;
      #1 chk("sys_type", excepttype, 32'h8);
      step();
      we_i = 0; clear_flags();
      chk("sys_epc", epc, 32'hbfc00100);
      rd(13); chk("sys_cause", rdata_o, 32'h00000020);
      rd(12); chk("sys_status", rdata_o, 32'h00400002);

      pcM = 32'hbfc00180;
      do_eret();
      rd(12); chk("eret_status", rdata_o, 32'h00400000);
      chk("eret_epc", epc, 32'hbfc00100);

      adesM = 1; bad_addrM = 32'h80000003; is_in_delayslotM = 1; pcM = 32'hbfc00204;
      #1 chk("ades_type", excepttype, 32'h5);
      step(); clear_flags();
      chk("ades_epc", epc, 32'hbfc00200);
      rd(13); chk("ades_cause", rdata_o, 32'h80000014);
      rd(8);  chk("ades_bva", rdata_o, 32'h80000003);

      // nested (EXL=1): code updates, EPC/BD held
      ovM = 1; adesM = 1; pcM = 32'hbfc00300;
      #1 chk("ov_prio", excepttype, 32'hc);
      step(); clear_flags();
      chk("nest_epc", epc, 32'hbfc00200);
      rd(13); chk("nest_cause", rdata_o, 32'h80000030);
      do_eret();
      rd(12); chk("eret2_status", rdata_o, 32'h00400000);
      chk("eret2_epc", epc, 32'hbfc00200);

      adel_ifM = 1; riM = 1; pcM = 32'hbfc00301;
      #1 chk("adelif_prio", excepttype, 32'h4);
      step(); clear_flags();
      chk("adelif_bva", badvaddr_o, 32'hbfc00301);
      chk("adelif_cause", cause_o, 32'h00000010);
      do_eret();

      // combinational priority only, cleared before the edge
      riM = 1; ovM = 1; #1 chk("ri_prio", excepttype, 32'ha);
      clear_flags();
      breakM = 1; eretM = 1; #1 chk("brk_prio", excepttype, 32'h9);
      clear_flags();
      adel_dataM = 1; adesM = 1; #1 chk("adeld_prio", excepttype, 32'h4);
      clear_flags();
      #1 chk("none_type", excepttype, 32'h0);

      instr_validM = 0;
      mtc0(5'd13, 32'hffffffff);
      chk("cause_wmask", cause_o, 32'h00000310);
      mtc0(5'd13, 32'h0);
      mtc0(5'd12, 32'h0000ff01);
      rd(12); chk("status_wr", rdata_o, 32'h0040ff01);

      int_i = 6'b000001; instr_validM = 1; pcM = 32'hbfc00400;
      #1 chk("int_latency", excepttype, 32'h0);
      instr_validM = 0;
      step();
      chk("int_bubble", excepttype, 32'h0);
      instr_validM = 1;
      #1 chk("int_taken", excepttype, 32'h1);
      step();
      chk("int_epc", epc, 32'hbfc00400);
      chk("int_cause", cause_o, 32'h00000400);
      chk("int_exl", excepttype, 32'h0);
      int_i = 0; instr_validM = 0;

`ifdef CP0_TIMER_EN
      mtc0(5'd9, 32'h0);
      mtc0(5'd11, 32'd10);
      chk("tmr_clear0", {31'b0, timer_int_o}, 32'h0);
      n = 2;
      while (!timer_int_o && n < 60) begin
         step();
         n++;
      end
      chk("tmr_rise", {31'b0, timer_int_o}, 32'h1);
      chk("tmr_lat_ok", {31'b0, (n == 20 || n == 21)}, 32'h1);
      rd(9); chk("tmr_count", rdata_o, 32'd10);
      mtc0(5'd11, 32'hffffffff);
      chk("tmr_clear", {31'b0, timer_int_o}, 32'h0);
      rd(11); chk("tmr_compare", rdata_o, 32'hffffffff);
`else
      mtc0(5'd9, 32'h5);
      mtc0(5'd11, 32'h5);
      rd(9);  chk("cnt_zero", rdata_o, 32'h0);
      rd(11); chk("cmp_zero", rdata_o, 32'h0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (timer_int_o) n++;
         step();
      end
      chk("tmr_never", n, 0);
`endif

      #2 rst = 1;
      #1;
      chk("arst_status", status_o, 32'h00400000);
      chk("arst_epc", epc, 32'h0);
      chk("arst_type", excepttype, 32'h0);
      rst = 0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
